// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT front-end: sample/frame types and the
// issue FSM states used by the frame buffer.
package fft_pkg;

  localparam int SAMPLE_W = 18;
  localparam int N_POINTS = 16;
  localparam int IDX_W    = $clog2(N_POINTS);

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef sample_t [N_POINTS-1:0]     frame_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

endpackage

// File: rtl/fft_capture_ram.sv
// 16-entry sample capture array: one indexed write port, whole-frame parallel read.
module fft_capture_ram
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  sample_t          wr_data,
  output frame_t           frame
);

  frame_t mem_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_reg <= '0;
    end else if (wr_en) begin
      mem_reg[wr_idx] <= wr_data;
    end
  end

  assign frame = mem_reg;

endmodule

// File: rtl/fft_frame_buffer.sv
// Double-buffered 16-sample frame collector feeding the FFT: captures a decimated
// sample stream, holds the last complete frame on t0..t15 and strobes new_t when the FFT is idle.
module fft_frame_buffer #(
  parameter int SAMPLE_W = 18,
  parameter int N_POINTS = 16,
  parameter int DECIM    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  input  logic                       fft_done,
  output logic                       new_t,
  output logic signed [SAMPLE_W-1:0] t0,
  output logic signed [SAMPLE_W-1:0] t1,
  output logic signed [SAMPLE_W-1:0] t2,
  output logic signed [SAMPLE_W-1:0] t3,
  output logic signed [SAMPLE_W-1:0] t4,
  output logic signed [SAMPLE_W-1:0] t5,
  output logic signed [SAMPLE_W-1:0] t6,
  output logic signed [SAMPLE_W-1:0] t7,
  output logic signed [SAMPLE_W-1:0] t8,
  output logic signed [SAMPLE_W-1:0] t9,
  output logic signed [SAMPLE_W-1:0] t10,
  output logic signed [SAMPLE_W-1:0] t11,
  output logic signed [SAMPLE_W-1:0] t12,
  output logic signed [SAMPLE_W-1:0] t13,
  output logic signed [SAMPLE_W-1:0] t14,
  output logic signed [SAMPLE_W-1:0] t15,
  output logic                       frame_pending,
  output logic [7:0]                 overrun_count
);

  import fft_pkg::*;

  if (SAMPLE_W != fft_pkg::SAMPLE_W || N_POINTS != fft_pkg::N_POINTS) begin : g_cfg_err
    $error("fft_frame_buffer: SAMPLE_W/N_POINTS must match fft_pkg (18/16)");
  end
  if (DECIM < 1 || DECIM > 255) begin : g_decim_err
    $error("fft_frame_buffer: DECIM must be in 1..255");
  end

  localparam logic [7:0]       DEC_LAST = 8'(DECIM - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_POINTS - 1);

  logic [7:0]       dec_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             accept;
  logic             frame_done;
  frame_t           cap_frame;
  frame_t           copy_frame;
  frame_t           pend_reg;
  logic             pend_flag_reg;
  logic [7:0]       ovr_reg;
  state_t           state_reg;
  state_t           state_next;

  assign accept     = sample_valid && (dec_reg == 8'd0);
  assign frame_done = accept && (idx_reg == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_reg <= '0;
      idx_reg <= '0;
    end else begin
      if (sample_valid) begin
        dec_reg <= (dec_reg == DEC_LAST) ? 8'd0 : dec_reg + 8'd1;
      end
      if (accept) begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  fft_capture_ram u_capture_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_idx  (idx_reg),
    .wr_data (sample_in),
    .frame   (cap_frame)
  );

  // The completing sample is still being written, so bypass it into the copy.
  for (genvar gi = 0; gi < N_POINTS; gi++) begin : g_copy
    assign copy_frame[gi] = (idx_reg == IDX_W'(gi)) ? sample_in : cap_frame[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg      <= '0;
      pend_flag_reg <= 1'b0;
      ovr_reg       <= '0;
    end else begin
      if (frame_done) begin
        pend_reg      <= copy_frame;
        pend_flag_reg <= 1'b1;
        // The ISSUE cycle hands the old frame to the FFT, so replacing it then is not a loss.
        if (pend_flag_reg && state_reg != ISSUE && ovr_reg != 8'hFF) begin
          ovr_reg <= ovr_reg + 8'd1;
        end
      end else if (state_reg == ISSUE) begin
        pend_flag_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // HOLDOFF masks the cycle in which the FFT has not yet dropped fft_done.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pend_flag_reg && fft_done) state_next = ISSUE;
      ISSUE:   state_next = HOLDOFF;
      HOLDOFF: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign new_t         = (state_reg == ISSUE);
  assign frame_pending = pend_flag_reg;
  assign overrun_count = ovr_reg;

  assign t0  = pend_reg[0];
  assign t1  = pend_reg[1];
  assign t2  = pend_reg[2];
  assign t3  = pend_reg[3];
  assign t4  = pend_reg[4];
  assign t5  = pend_reg[5];
  assign t6  = pend_reg[6];
  assign t7  = pend_reg[7];
  assign t8  = pend_reg[8];
  assign t9  = pend_reg[9];
  assign t10 = pend_reg[10];
  assign t11 = pend_reg[11];
  assign t12 = pend_reg[12];
  assign t13 = pend_reg[13];
  assign t14 = pend_reg[14];
  assign t15 = pend_reg[15];

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer: expected frames are queued as frames complete
// and compared against the t values captured on every new_t pulse.
module tb_fft_frame_buffer;

  logic clk = 1'b0;
  logic reset;
  logic signed [17:0] sample_in, sample_in4;
  logic sample_valid, sample_valid4;
  logic fft_done, fft_done4;
  logic new_t, new_t4;
  logic frame_pending, frame_pending4;
  logic [7:0] overrun_count, overrun_count4;
  wire [287:0] t_vec;
  wire [287:0] t4_vec;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wide_cnt = 0;
  int pulses4  = 0;
  logic new_t_prev = 1'b0;
  logic [287:0] exp_q[$];
  logic [287:0] got_q[$];
  int cyc_q[$];
  int last_pulse = 0;
  int n_pulses   = 0;

  always #5 clk = ~clk;

  fft_frame_buffer dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .fft_done(fft_done), .new_t(new_t),
    .t0(t_vec[0*18 +: 18]),   .t1(t_vec[1*18 +: 18]),   .t2(t_vec[2*18 +: 18]),
    .t3(t_vec[3*18 +: 18]),   .t4(t_vec[4*18 +: 18]),   .t5(t_vec[5*18 +: 18]),
    .t6(t_vec[6*18 +: 18]),   .t7(t_vec[7*18 +: 18]),   .t8(t_vec[8*18 +: 18]),
    .t9(t_vec[9*18 +: 18]),   .t10(t_vec[10*18 +: 18]), .t11(t_vec[11*18 +: 18]),
    .t12(t_vec[12*18 +: 18]), .t13(t_vec[13*18 +: 18]), .t14(t_vec[14*18 +: 18]),
    .t15(t_vec[15*18 +: 18]),
    .frame_pending(frame_pending), .overrun_count(overrun_count)
  );

  fft_frame_buffer #(.DECIM(4)) dut4 (
    .clk(clk), .reset(reset), .sample_in(sample_in4), .sample_valid(sample_valid4),
    .fft_done(fft_done4), .new_t(new_t4),
    .t0(t4_vec[0*18 +: 18]),   .t1(t4_vec[1*18 +: 18]),   .t2(t4_vec[2*18 +: 18]),
    .t3(t4_vec[3*18 +: 18]),   .t4(t4_vec[4*18 +: 18]),   .t5(t4_vec[5*18 +: 18]),
    .t6(t4_vec[6*18 +: 18]),   .t7(t4_vec[7*18 +: 18]),   .t8(t4_vec[8*18 +: 18]),
    .t9(t4_vec[9*18 +: 18]),   .t10(t4_vec[10*18 +: 18]), .t11(t4_vec[11*18 +: 18]),
    .t12(t4_vec[12*18 +: 18]), .t13(t4_vec[13*18 +: 18]), .t14(t4_vec[14*18 +: 18]),
    .t15(t4_vec[15*18 +: 18]),
    .frame_pending(frame_pending4), .overrun_count(overrun_count4)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record what the FFT would latch: the t values while new_t is high.
  always @(negedge clk) begin
    if (new_t) begin
      got_q.push_back(t_vec);
      cyc_q.push_back(cyc);
      if (new_t_prev) wide_cnt <= wide_cnt + 1;
    end
    if (new_t4) pulses4 <= pulses4 + 1;
    new_t_prev <= new_t;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [287:0] mk_frame(input int base, input int stride);
    logic [287:0] f;
    for (int i = 0; i < 16; i++) f[i*18 +: 18] = 18'(base + i * stride);
    return f;
  endfunction

  task automatic send(input logic [287:0] f, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      sample_in    = f[i*18 +: 18];
      sample_valid = 1'b1;
      step();
    end
    sample_valid = 1'b0;
  endtask

  // Compare every recorded new_t pulse against the scoreboard, in order.
  task automatic drain(input int n_expected);
    logic [287:0] got;
    logic [287:0] exp;
    int c;
    chk("new_t_pulse_count", 32'(got_q.size()), 32'(n_expected));
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      c   = cyc_q.pop_front();
      if (n_pulses > 0) chk("new_t_spacing_ge3", 32'(c - last_pulse >= 3), 32'd1);
      last_pulse = c;
      n_pulses++;
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL new_t_unexpected: observed t=%h expected no pulse", got);
      end
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        chk_vec("frame_at_new_t", got, exp);
      end
    end
  endtask

  initial begin
    logic [287:0] f, a, b;
    reset = 1'b1;
    sample_in = '0; sample_valid = 1'b0; fft_done = 1'b1;
    sample_in4 = '0; sample_valid4 = 1'b0; fft_done4 = 1'b1;
    repeat (3) step();
    chk("reset_new_t", 32'(new_t), 32'd0);
    chk("reset_frame_pending", 32'(frame_pending), 32'd0);
    chk("reset_overrun", 32'(overrun_count), 32'd0);
    chk_vec("reset_t", t_vec, '0);
    reset = 1'b0;
    step();

    // Basic frame 1..16 with the FFT idle: new_t two cycles after sample 16.
    f = mk_frame(1, 1);
    send(f, 0, 16);
    exp_q.push_back(f);
    chk("basic_pending_after_copy", 32'(frame_pending), 32'd1);
    chk("basic_new_t_latency1", 32'(new_t), 32'd0);
    chk("basic_t0", 32'(t_vec[0 +: 18]), 32'd1);
    chk("basic_t15", 32'(t_vec[15*18 +: 18]), 32'd16);
    step();
    chk("basic_new_t_latency2", 32'(new_t), 32'd1);
    step();
    chk("basic_new_t_one_cycle", 32'(new_t), 32'd0);
    chk("basic_pending_cleared", 32'(frame_pending), 32'd0);
    step();
    drain(1);

    // Decimation by 4 on the second instance.
    for (int v = 0; v < 64; v++) begin
      sample_in4 = 18'(v);
      sample_valid4 = 1'b1;
      step();
    end
    sample_valid4 = 1'b0;
    repeat (4) step();
    chk("decim_pulses", 32'(pulses4), 32'd1);
    chk_vec("decim_frame", t4_vec, mk_frame(0, 4));
    chk("decim_pending", 32'(frame_pending4), 32'd0);
    chk("decim_overrun", 32'(overrun_count4), 32'd0);

    // FFT busy for 100 cycles with a frame waiting.
    fft_done = 1'b0;
    f = mk_frame(100, 3);
    send(f, 0, 16);
    exp_q.push_back(f);
    chk("hold_pending", 32'(frame_pending), 32'd1);
    for (int i = 0; i < 100; i++) begin
      chk("hold_new_t_low", 32'(new_t), 32'd0);
      chk_vec("hold_t_stable", t_vec, f);
      step();
    end
    fft_done = 1'b1;
    step();
    chk("hold_release_new_t", 32'(new_t), 32'd1);
    step();
    step();
    drain(1);

    // Frame B completes in the ISSUE cycle of frame A.
    fft_done = 1'b0;
    a = mk_frame(-50, -7);
    b = mk_frame(-100000, 9);
    send(a, 0, 16);
    exp_q.push_back(a);
    send(b, 0, 15);
    fft_done = 1'b1;
    step();
    chk("simul_issue_a", 32'(new_t), 32'd1);
    sample_in = b[15*18 +: 18];
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    exp_q.push_back(b);
    chk("simul_new_t_low", 32'(new_t), 32'd0);
    chk("simul_pending_kept", 32'(frame_pending), 32'd1);
    chk_vec("simul_holds_b", t_vec, b);
    chk("simul_no_overrun", 32'(overrun_count), 32'd0);
    step();
    chk("simul_holdoff_gap", 32'(new_t), 32'd0);
    step();
    chk("simul_issue_b", 32'(new_t), 32'd1);
    step();
    step();
    drain(2);

    // Three frames while busy, then saturation of the overrun counter.
    fft_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      f = mk_frame(200 + 100 * k, 1);
      send(f, 0, 16);
      if (k == 0) exp_q.push_back(f);
      else exp_q[exp_q.size() - 1] = f;
    end
    chk("overrun_two", 32'(overrun_count), 32'd2);
    chk_vec("overrun_holds_third", t_vec, mk_frame(400, 1));
    fft_done = 1'b1;
    step();
    chk("overrun_release_new_t", 32'(new_t), 32'd1);
    step();
    step();
    drain(1);
    fft_done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      f = mk_frame(1000 + 16 * k, 1);
      send(f, 0, 16);
      if (k == 0) exp_q.push_back(f);
      else exp_q[exp_q.size() - 1] = f;
    end
    chk("overrun_saturated", 32'(overrun_count), 32'd255);
    fft_done = 1'b1;
    step();
    chk("saturate_release_new_t", 32'(new_t), 32'd1);
    step();
    step();
    drain(1);
    chk("overrun_still_255", 32'(overrun_count), 32'd255);

    // Reset at sample 9 discards the partial frame.
    send(mk_frame(7000, 1), 0, 9);
    reset = 1'b1;
    step();
    chk("midreset_new_t", 32'(new_t), 32'd0);
    chk("midreset_pending", 32'(frame_pending), 32'd0);
    chk("midreset_overrun", 32'(overrun_count), 32'd0);
    chk_vec("midreset_t", t_vec, '0);
    reset = 1'b0;
    f = mk_frame(9000, 2);
    send(f, 0, 15);
    repeat (3) step();
    chk("fresh15_no_pending", 32'(frame_pending), 32'd0);
    chk("fresh15_no_new_t", 32'(new_t), 32'd0);
    send(f, 15, 1);
    exp_q.push_back(f);
    chk("fresh16_pending", 32'(frame_pending), 32'd1);
    step();
    chk("fresh16_new_t", 32'(new_t), 32'd1);
    step();
    step();
    drain(1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("new_t_never_wide", 32'(wide_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
